ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder/controller in the miniRV core.
- Owns the PC.
- Issues one word fetch at a time to instruction memory over a req/rvalid interface.
- Holds the returned instruction for decode under a valid/ready handshake.
- Computes and applies control-flow redirects using the decoder's 2-bit npc_op encoding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
NOP_INST, 32'h0000_0013, value driven on inst while no valid instruction is held (addi x0,x0,0).

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  one-cycle fetch request pulse, registered.
imem_addr  out  32  fetch address; equals pc, stable from req until rvalid.
imem_rvalid  in  1  response valid; arrives >=1 cycle after imem_req; at most one outstanding.
imem_rdata  in  32  instruction word, valid with imem_rvalid.
inst_valid  out  1  inst/inst_pc/inst_pc4 hold a live instruction.
inst_ready  in  1  decode accepts instruction when inst_valid & inst_ready.
inst  out  32  instruction to decoder.
inst_pc  out  32  address of inst.
inst_pc4  out  32  inst_pc + 4.
redir_valid  in  1  control instruction resolved this cycle; flush and refetch.
npc_op  in  2  00 branch, 01 jalr, 10 sequential, 11 jal.
br_taken  in  1  branch condition (npc_op==00 only).
redir_pc  in  32  PC of the resolving instruction.
redir_imm  in  32  sign-extended immediate.
redir_rs1  in  32  rs1 value (jalr base).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, imem_req=0, inst_valid=0, inst=NOP_INST. The first imem_req pulse occurs in the first clock after rst_n rises.
- State machine states:
  - REQ: imem_req=1 for exactly this cycle; next state WAIT.
  - WAIT: on rvalid, register rdata into inst, set inst_valid, go to HOLD.
  - HOLD: inst_valid=1. On inst_ready: clear inst_valid, pc<=pc+4, go to REQ.
  - DROP: a response is still outstanding for a squashed fetch. On rvalid, discard rdata and go to REQ.
- Latency: with a 1-cycle memory, REQ at t, rvalid at t+1, inst_valid at t+2. Minimum issue period is 3 cycles.
- Redirect target (32-bit, wrap mod 2^32):
  - 00: br_taken ? redir_pc+redir_imm : redir_pc+4
  - 01: (redir_rs1+redir_imm) & ~1
  - 10: redir_pc+4
  - 11: redir_pc+redir_imm
- Every redir_valid flushes unconditionally, including not-taken and npc_op=10. On redir_valid: pc<=target, inst_valid<=0, inst<=NOP_INST.
- Next state after redir_valid, by current state:
  - REQ: DROP.
  - WAIT without rvalid: DROP.
  - WAIT with rvalid: REQ (data discarded).
  - HOLD: REQ.
  - DROP without rvalid: DROP.
  - DROP with rvalid: REQ.
- Priority: redir_valid beats inst_ready in the same cycle. pc takes the target, not pc+4. Decode must squash anything it accepted that cycle.
- imem_addr changes only in cycles with no outstanding request, so it is stable over REQ..rvalid.
- rvalid in REQ or HOLD is a protocol violation; it is ignored.
- Reset mid-operation: asynchronous return to reset values. Any in-flight response after reset is not tracked; the memory must also be reset.
- Without the optional feature: target bits [1:0] are forced to 0 before loading pc.

Optional Feature:
IFU_MISALIGN_CHK_EN
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect target with bits[1:0]!=0 sets misalign_err sticky.
  - pc loads the raw target; the FSM enters HALT after any outstanding response drains.
  - No further imem_req; inst_valid=0 until reset.
- Undefined: port absent, low bits masked, no HALT state.

Test Plan:
- Reset release, 1-cycle memory returning 0x00500093 for addr 0, inst_ready=1 → imem_req at cycle 1, addr 0. inst_valid at cycle 3 with inst_pc=0, inst_pc4=4. Next req addr 4 at cycle 4.
- inst_ready=0 for 5 cycles in HOLD → inst/inst_pc stable, no imem_req. Ready raised → single handshake, next addr pc+4.
- redir_valid npc_op=11, redir_pc=0x10, imm=0x20 in HOLD → inst_valid drops next cycle, next req addr 0x30.
- npc_op=00, br_taken=0, redir_pc=0x40 during WAIT with 3-cycle memory → DROP. Stale rdata discarded (never on inst), then req addr 0x44.
- npc_op=01, rs1=0x103, imm=0x4 → target 0x106 (LSB cleared). Without IFU_MISALIGN_CHK_EN pc=0x104. With it, misalign_err=1 and no further imem_req.
- redir_valid and inst_ready same cycle in HOLD at pc=0x8, jal imm=-8 from redir_pc=0x8 → next req addr 0x0, not 0xC.

Source files
------------

// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_unit: miniRV fetch stage: PC, single-outstanding imem fetch, decode |
// | hand-off and npc_op redirects. Option: IFU_MISALIGN_CHK_EN.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        redir_valid,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] redir_pc,
    input  logic [31:0] redir_imm,
    input  logic [31:0] redir_rs1
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

`ifdef IFU_MISALIGN_CHK_EN
    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] target_raw;
    logic [31:0] target;
`ifdef IFU_MISALIGN_CHK_EN
    logic        err_q, err_d;
`endif

    always_comb begin
        target_raw = redir_pc + redir_imm;
        case (npc_op)
            2'b00:   target_raw = br_taken ? (redir_pc + redir_imm) : (redir_pc + 32'd4);
            2'b01:   target_raw = (redir_rs1 + redir_imm) & ~32'd1;
            2'b10:   target_raw = redir_pc + 32'd4;
            default: target_raw = redir_pc + redir_imm;
        endcase
`ifdef IFU_MISALIGN_CHK_EN
        target = target_raw;
`else
        target = target_raw & ~32'd3;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        inst_d  = inst_q;
`ifdef IFU_MISALIGN_CHK_EN
        err_d   = err_q;
`endif
        if (redir_valid) begin
            pc_d    = target;
            valid_d = 1'b0;
            inst_d  = NOP_INST;
`ifdef IFU_MISALIGN_CHK_EN
            err_d   = err_q | (target_raw[1:0] != 2'b00);
`endif
            // A flush with a response still in flight must drain it in DROP.
            case (state_q)
                S_REQ:   state_d = req_q ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
                default: state_d = state_q;
            endcase
        end else begin
            // REQ with req_q low only occurs straight out of reset: arm the pulse.
            case (state_q)
                S_REQ:   state_d = req_q ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst_d  = imem_rdata;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = state_q;
            endcase
        end
`ifdef IFU_MISALIGN_CHK_EN
        if (err_d && (state_d == S_REQ)) begin
            state_d = S_HALT;
        end
`endif
        req_d = (state_d == S_REQ);
        if (state_d == S_REQ) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
`ifdef IFU_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
`ifdef IFU_MISALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = pc_q;
    assign inst_pc4   = pc_q + 32'd4;
`ifdef IFU_MISALIGN_CHK_EN
    assign misalign_err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifetch_unit: directed bench for ifetch_unit with a fetch-level model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redir_valid;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] redir_pc;
    logic [31:0] redir_imm;
    logic [31:0] redir_rs1;
`ifdef IFU_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    ifetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4),
        .redir_valid (redir_valid),
        .npc_op      (npc_op),
        .br_taken    (br_taken),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_rs1   (redir_rs1)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return {a[23:0], 8'h13};
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] op, input logic tk,
                                                 input logic [31:0] pc, input logic [31:0] imm,
                                                 input logic [31:0] rs1);
        logic [31:0] t;
        case (op)
            2'b00:   t = tk ? pc + imm : pc + 32'd4;
            2'b01:   t = (rs1 + imm) & 32'hFFFF_FFFE;
            2'b10:   t = pc + 32'd4;
            default: t = pc + imm;
        endcase
`ifndef IFU_MISALIGN_CHK_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory: answers each request mem_lat cycles later with memword(addr).
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req) begin
                m_pend = 1'b1;
                m_cnt  = mem_lat;
                m_addr = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memword(m_addr);
                    m_pend      = 1'b0;
                end
            end
        end
    end

    // Fetch-level model: architectural PC, outstanding/squashed response, held-instruction flag.
    logic [31:0] x_pc, x_out_addr, x_tgt;
    logic        x_out, x_sq, x_valid, x_req, x_first, x_mis;
    logic        rv_sq, hs, mis_n, nv, nr;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                x_pc = 32'd0; x_out = 1'b0; x_out_addr = 32'd0; x_sq = 1'b0;
                x_valid = 1'b0; x_req = 1'b0; x_first = 1'b1; x_mis = 1'b0;
            end else begin
                chk("req", {31'd0, imem_req}, {31'd0, x_req});
                chk("valid", {31'd0, inst_valid}, {31'd0, x_valid});
                if (x_req) chk("req_addr", imem_addr, x_pc);
                if (x_out) chk("addr_stable", imem_addr, x_out_addr);
                if (x_valid) begin
                    chk("inst_pc", inst_pc, x_pc);
                    chk("inst", inst, memword(x_pc));
                    chk("inst_pc4", inst_pc4, x_pc + 32'd4);
                end else begin
                    chk("inst_nop", inst, NOP);
                end
`ifdef IFU_MISALIGN_CHK_EN
                chk("misalign_err", {31'd0, misalign_err}, {31'd0, x_mis});
`endif
                rv_sq = imem_rvalid && x_sq;
                if (imem_rvalid) begin x_out = 1'b0; x_sq = 1'b0; end
                if (x_req) begin x_out = 1'b1; x_out_addr = x_pc; end
                hs = x_valid && inst_ready && !redir_valid;
                if (redir_valid && x_out) x_sq = 1'b1;
                x_tgt = model_target(npc_op, br_taken, redir_pc, redir_imm, redir_rs1);
                mis_n = x_mis || (redir_valid && (x_tgt[1:0] != 2'b00));
                nv = !mis_n && ((imem_rvalid && !rv_sq && !redir_valid) ||
                                (x_valid && !inst_ready && !redir_valid));
                nr = !mis_n && (x_first || (!x_out && (hs || redir_valid || rv_sq)));
                if (redir_valid) x_pc = x_tgt;
                else if (hs)     x_pc = x_pc + 32'd4;
                x_valid = nv;
                x_req   = nr;
                x_first = 1'b0;
                x_mis   = mis_n;
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic redir(input logic [1:0] op, input logic tk, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1);
        redir_valid = 1'b1; npc_op = op; br_taken = tk;
        redir_pc = pc; redir_imm = imm; redir_rs1 = rs1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; inst_ready = 1'b1; redir_valid = 1'b0; npc_op = 2'b10;
        br_taken = 1'b0; redir_pc = 32'd0; redir_imm = 32'd0; redir_rs1 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        rst_n = 1'b1;
        cyc = 0;

        goto(1);  #2; chk("c1_req", {31'd0, imem_req}, 32'd1); chk("c1_addr", imem_addr, 32'h0);
        goto(3);  #2; chk("c3_valid", {31'd0, inst_valid}, 32'd1);
                      chk("c3_inst", inst, 32'h0050_0093);
                      chk("c3_pc", inst_pc, 32'h0); chk("c3_pc4", inst_pc4, 32'h4);
        goto(4);  inst_ready = 1'b0;
                  #2; chk("c4_req", {31'd0, imem_req}, 32'd1); chk("c4_addr", imem_addr, 32'h4);
        goto(10); #2; chk("stall_inst", inst, 32'h0000_0413); chk("stall_pc", inst_pc, 32'h4);
                      chk("stall_req", {31'd0, imem_req}, 32'd0);
        goto(11); inst_ready = 1'b1;
        goto(12); inst_ready = 1'b0;
                  #2; chk("c12_req", {31'd0, imem_req}, 32'd1); chk("c12_addr", imem_addr, 32'h8);
        // Redirect beats the same-cycle handshake: jal -8 from 0x8.
        goto(14); inst_ready = 1'b1; redir(2'b11, 1'b0, 32'h8, 32'hFFFF_FFF8, 32'h0);
        goto(15); inst_ready = 1'b0; redir_valid = 1'b0;
                  #2; chk("prio_addr", imem_addr, 32'h0); chk("prio_req", {31'd0, imem_req}, 32'd1);
        goto(17); redir(2'b11, 1'b0, 32'h10, 32'h20, 32'h0); mem_lat = 3;
        goto(18); redir_valid = 1'b0;
                  #2; chk("jal_valid", {31'd0, inst_valid}, 32'd0); chk("jal_addr", imem_addr, 32'h30);
        goto(19); redir(2'b00, 1'b0, 32'h40, 32'h100, 32'h0);
        goto(20); redir_valid = 1'b0;
                  #2; chk("drop_req", {31'd0, imem_req}, 32'd0); chk("drop_addr", imem_addr, 32'h30);
        goto(22); #2; chk("ntk_addr", imem_addr, 32'h44); chk("ntk_req", {31'd0, imem_req}, 32'd1);
                      chk("ntk_inst", inst, 32'h0000_0013);
        goto(26); #2; chk("c26_inst", inst, 32'h0000_4413); chk("c26_pc", inst_pc, 32'h44);
        redir(2'b01, 1'b0, 32'h44, 32'h4, 32'h103); mem_lat = 1;
        goto(27); redir_valid = 1'b0; inst_ready = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
                  #2; chk("mis_err", {31'd0, misalign_err}, 32'd1);
                      chk("mis_req", {31'd0, imem_req}, 32'd0);
`else
                  #2; chk("jalr_addr", imem_addr, 32'h104);
                      chk("jalr_req", {31'd0, imem_req}, 32'd1);
        goto(29); #2; chk("c29_inst", inst, 32'h0001_0413);
        goto(30); redir(2'b10, 1'b0, 32'h200, 32'h0, 32'h0);
                  #2; chk("c30_addr", imem_addr, 32'h108);
        goto(31); redir(2'b00, 1'b1, 32'h300, 32'h10, 32'h0);
        goto(32); redir_valid = 1'b0; br_taken = 1'b0;
                  #2; chk("tk_addr", imem_addr, 32'h310); chk("tk_req", {31'd0, imem_req}, 32'd1);
        goto(34); #2; chk("c34_pc", inst_pc, 32'h310); chk("c34_inst", inst, 32'h0003_1013);
        goto(36); redir(2'b11, 1'b0, 32'h400, 32'h100, 32'h0);
        goto(37); redir_valid = 1'b0;
                  #2; chk("wrv_addr", imem_addr, 32'h500); chk("wrv_valid", {31'd0, inst_valid}, 32'd0);
`endif
        for (int i = 0; i < 30; i++) begin
            goto(cyc + 1);
            inst_ready = ((i % 3) != 0);
        end
        goto(cyc + 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
